// File: rtl/pump_axi_responder_pkg.sv
// rtl/pump_axi_responder_pkg.sv - shared pump definitions: FSM encoding, AXI constants, error bits, memory map
package pump_axi_responder_pkg;

  // One-hot encoding keeps next-state and output decode to single-bit tests
  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_WR_REQ  = 7'b000_0010,
    ST_WR_RESP = 7'b000_0100,
    ST_DONE_WR = 7'b000_1000,
    ST_RD_REQ  = 7'b001_0000,
    ST_RD_RESP = 7'b010_0000,
    ST_DONE_RD = 7'b100_0000
  } pump_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Bit positions inside err_flags
  localparam int ERR_OVERLAP  = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_BAD_RESP = 2;
  localparam int ERR_TIMEOUT  = 3;

  // Exchannel memory windows: channel n lives at base + n * stride
  localparam logic [31:0] EXCHANNEL0_BASE_ADDR = 32'hA000_0000;
  localparam logic [31:0] EXCHANNEL_STRIDE     = 32'h0200_0000;

endpackage

// File: rtl/pump_axi_timeout.sv
// rtl/pump_axi_timeout.sv - per-phase wait counter with restart and expiry flag
module pump_axi_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic start,
  output logic expired
);

  localparam logic [15:0] LIMIT_M1 = 16'(LIMIT - 1);

  logic [15:0] cnt;
  logic [15:0] cur;

  // clear restarts the count in the same cycle, so the first waiting cycle is cycle zero
  assign cur     = clear ? 16'd0 : cnt;
  assign expired = start && (cur >= LIMIT_M1);

  // Count waiting cycles, saturating so a stuck slave cannot wrap the counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= 16'd0;
    end else if (start && (cur != 16'hFFFF)) begin
      cnt <= cur + 16'd1;
    end else begin
      cnt <= cur;
    end
  end

endmodule

// File: rtl/pump_axi_responder.sv
// rtl/pump_axi_responder.sv - turns pump single-word requests into AXI4-Lite master transactions
module pump_axi_responder
  import pump_axi_responder_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_done,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_done,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic                busy,
  output logic [3:0]          err_flags,
  input  logic                err_clr
);

  pump_state_e state;
  logic        tmo_clr;
  logic        tmo_wait;
  logic        tmo_expired;
  logic [3:0]  err_set;

  // Only full-word writes are issued
  assign m_axi_wstrb = '1;

  assign tmo_wait = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                    (state == ST_RD_REQ) || (state == ST_RD_RESP);

  pump_axi_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (tmo_clr),
    .start   (tmo_wait),
    .expired (tmo_expired)
  );

  // Collect this cycle's error events; a write wins over a simultaneous read
  always_comb begin
    err_set = 4'b0000;
    if (state == ST_IDLE) begin
      err_set[ERR_OVERLAP] = wr_en && rd_en;
      if (wr_en) begin
        err_set[ERR_MISALIGN] = (wr_addr[1:0] != 2'b00);
      end else if (rd_en) begin
        err_set[ERR_MISALIGN] = (rd_addr[1:0] != 2'b00);
      end
    end else begin
      err_set[ERR_OVERLAP] = wr_en || rd_en;
    end
    if ((state == ST_WR_RESP) && m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY)) begin
      err_set[ERR_BAD_RESP] = 1'b1;
    end
    if ((state == ST_RD_RESP) && m_axi_rvalid && (m_axi_rresp != AXI_RESP_OKAY)) begin
      err_set[ERR_BAD_RESP] = 1'b1;
    end
    err_set[ERR_TIMEOUT] = tmo_expired;
  end

  // Sticky error flags; clearing beats any event landing in the same cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_flags <= 4'b0000;
    end else if (err_clr) begin
      err_flags <= 4'b0000;
    end else begin
      err_flags <= err_flags | err_set;
    end
  end

  // Request FSM with registered AXI handshake and completion outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      tmo_clr       <= 1'b1;
      busy          <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      tmo_clr  <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            m_axi_awaddr  <= {wr_addr[ADDR_W-1:2], 2'b00};
            m_axi_wdata   <= wr_data;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            busy          <= 1'b1;
            tmo_clr       <= 1'b1;
            state         <= ST_WR_REQ;
          end else if (rd_en) begin
            m_axi_araddr  <= {rd_addr[ADDR_W-1:2], 2'b00};
            m_axi_arvalid <= 1'b1;
            busy          <= 1'b1;
            tmo_clr       <= 1'b1;
            state         <= ST_RD_REQ;
          end
        end
        ST_WR_REQ: begin
          // A dropped valid means that channel already handshook
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready) m_axi_wvalid <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            tmo_clr      <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            wr_done      <= 1'b1;
            tmo_clr      <= 1'b1;
            state        <= ST_DONE_WR;
          end
        end
        ST_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            tmo_clr       <= 1'b1;
            state         <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axi_rvalid) begin
            rd_data      <= m_axi_rdata;
            m_axi_rready <= 1'b0;
            rd_valid     <= 1'b1;
            rd_done      <= 1'b1;
            tmo_clr      <= 1'b1;
            state        <= ST_DONE_RD;
          end
        end
        ST_DONE_WR, ST_DONE_RD: begin
          busy    <= 1'b0;
          tmo_clr <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b0;
          busy          <= 1'b0;
          tmo_clr       <= 1'b1;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pump_axi_responder.sv
// tb/tb_pump_axi_responder.sv - directed-vector bench for pump_axi_responder with a latency-programmable AXI slave
module tb_pump_axi_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en, rd_en, err_clr;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        wr_done, rd_valid, rd_done, busy;
  logic [31:0] rd_data;
  logic [3:0]  err_flags;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  int aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic aw_got, w_got, r_pend;
  int aw_hs_n, ar_hs_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pump_axi_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .busy(busy), .err_flags(err_flags), .err_clr(err_clr)
  );

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid && (w_cnt >= w_lat);
  assign arready = arvalid && (ar_cnt >= ar_lat);
  assign bresp   = bresp_cfg;
  assign rresp   = 2'b00;
  assign rdata   = rdata_cfg;

  // AXI slave model: ready after a programmed wait, B once both AW and W land, R r_lat cycles after AR
  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
      aw_hs_n <= 0; ar_hs_n <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) aw_hs_n <= aw_hs_n + 1;
      if (arvalid && arready) ar_hs_n <= ar_hs_n + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready) w_got <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        if (r_lat == 0) rvalid <= 1'b1;
        else begin
          r_pend <= 1'b1;
          r_cnt  <= r_lat - 1;
        end
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          rvalid <= 1'b1;
          r_pend <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc, done_cyc, aw_hi, w_hi, done_n, aw0, ar0;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;

    // reset state
    check("rst_ctl", {23'd0, awvalid, wvalid, bready, arvalid, rready, wr_done, rd_done, rd_valid, busy}, 32'h0);
    check("rst_err", {28'd0, err_flags}, 32'h0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", {28'd0, wstrb}, 32'hF);

    // zero-wait write
    wr_addr = 32'hA000_0010; wr_data = 32'hDEAD_BEEF; wr_en = 1'b1;
    step(1); wr_en = 1'b0;
    check("w1_awvalid", {31'd0, awvalid}, 32'd1);
    check("w1_wvalid", {31'd0, wvalid}, 32'd1);
    check("w1_awaddr", awaddr, 32'hA000_0010);
    check("w1_wdata", wdata, 32'hDEAD_BEEF);
    check("w1_busy", {31'd0, busy}, 32'd1);
    check("w1_done_c1", {31'd0, wr_done}, 32'd0);
    step(1);
    check("w1_bready_c2", {31'd0, bready}, 32'd1);
    check("w1_done_c2", {31'd0, wr_done}, 32'd0);
    step(1);
    check("w1_done_c3", {31'd0, wr_done}, 32'd1);
    step(1);
    check("w1_done_c4", {31'd0, wr_done}, 32'd0);
    check("w1_idle", {31'd0, busy}, 32'd0);
    check("w1_err", {28'd0, err_flags}, 32'h0);

    // read with data returned two cycles after the address handshake
    r_lat = 2; rdata_cfg = 32'h1234_5678;
    rd_addr = 32'h1000_0004; rd_en = 1'b1;
    step(1); rd_en = 1'b0;
    check("r2_araddr", araddr, 32'h1000_0004);
    check("r2_arvalid", {31'd0, arvalid}, 32'd1);
    hs_cyc = -1; done_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (rvalid && rready && hs_cyc < 0) hs_cyc = c;
      if (rd_done && done_cyc < 0) begin
        done_cyc = c;
        check("r2_rd_valid", {31'd0, rd_valid}, 32'd1);
        check("r2_rd_data", rd_data, 32'h1234_5678);
      end
      step(1);
    end
    check("r2_hs_cycle", hs_cyc, 32'd4);
    check("r2_done_cycle", done_cyc, 32'd5);
    rdata_cfg = 32'hFFFF_0000; r_lat = 0;

    // write with awready delayed 3 cycles, wready immediate
    aw_lat = 3;
    wr_addr = 32'hA000_0020; wr_data = 32'h0000_0055; wr_en = 1'b1;
    step(1); wr_en = 1'b0;
    aw_hi = 0; w_hi = 0; done_n = 0;
    for (int c = 1; c <= 15; c++) begin
      aw_hi += int'(awvalid);
      w_hi += int'(wvalid);
      done_n += int'(wr_done);
      step(1);
    end
    check("w3_aw_cycles", aw_hi, 32'd4);
    check("w3_w_cycles", w_hi, 32'd1);
    check("w3_done_count", done_n, 32'd1);
    check("w3_err", {28'd0, err_flags}, 32'h0);
    check("w3_rd_data_held", rd_data, 32'h1234_5678);
    aw_lat = 0;

    // simultaneous wr_en/rd_en, then rd_en during WR_RESP
    aw0 = aw_hs_n; ar0 = ar_hs_n;
    wr_addr = 32'hA000_0040; wr_data = 32'h0000_0077; rd_addr = 32'h1000_0010;
    wr_en = 1'b1; rd_en = 1'b1;
    step(1); wr_en = 1'b0; rd_en = 1'b0;
    step(1);
    check("ov_in_wr_resp", {31'd0, bready}, 32'd1);
    rd_en = 1'b1;
    step(1); rd_en = 1'b0;
    check("ov_wr_done", {31'd0, wr_done}, 32'd1);
    step(6);
    check("ov_aw_count", aw_hs_n - aw0, 32'd1);
    check("ov_ar_count", ar_hs_n - ar0, 32'd0);
    check("ov_err", {28'd0, err_flags}, 32'h1);
    err_clr = 1'b1;
    step(1); err_clr = 1'b0;
    check("ov_err_clr", {28'd0, err_flags}, 32'h0);

    // error response on a misaligned write
    bresp_cfg = 2'b10;
    wr_addr = 32'hA000_0002; wr_data = 32'h0000_0099; wr_en = 1'b1;
    step(1); wr_en = 1'b0;
    check("br_awaddr", awaddr, 32'hA000_0000);
    done_n = 0;
    for (int c = 1; c <= 8; c++) begin
      done_n += int'(wr_done);
      step(1);
    end
    check("br_done_count", done_n, 32'd1);
    check("br_err", {28'd0, err_flags}, 32'h6);
    bresp_cfg = 2'b00;
    err_clr = 1'b1;
    step(1); err_clr = 1'b0;

    // timeout on a stuck AR channel, then reset mid-transaction
    ar_lat = 1000;
    rd_addr = 32'h1000_0008; rd_en = 1'b1;
    step(1); rd_en = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 8) check("to_c8", {31'd0, err_flags[3]}, 32'd0);
      if (c == 9) check("to_c9", {31'd0, err_flags[3]}, 32'd1);
      step(1);
    end
    check("to_arvalid_held", {31'd0, arvalid}, 32'd1);
    check("to_araddr_held", araddr, 32'h1000_0008);
    rstn = 1'b0;
    step(1);
    check("to_rst_ctl", {23'd0, awvalid, wvalid, bready, arvalid, rready, wr_done, rd_done, rd_valid, busy}, 32'h0);
    check("to_rst_err", {28'd0, err_flags}, 32'h0);
    check("to_rst_rd_data", rd_data, 32'h0);
    check("to_rst_addr", awaddr | araddr | wdata, 32'h0);
    rstn = 1'b1; ar_lat = 0;
    step(1);

    // FSM serves a fresh read after reset with zero-wait latency
    rdata_cfg = 32'hCAFE_0001;
    rd_addr = 32'h1000_000C; rd_en = 1'b1;
    step(1); rd_en = 1'b0;
    step(2);
    check("pr_rd_done_c3", {31'd0, rd_done}, 32'd1);
    check("pr_rd_data", rd_data, 32'hCAFE_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
